binary_search_guesser: RTL

Sequential search engine that finds an unknown WIDTH-bit value by binary search, using the three-flag magnitude result (EQ/LT/GT) of an external comparator. It drives a probe value GUESS into the comparator's A input, while the secret value drives B. It samples the flags, narrows its range, and reports the found value, the probe count and an inconsistency error. It is the initiator that consumes comparator results in the number-guessing lab datapath.

---
 rtl/binary_search_guesser.sv | 135 +++++++++++++
 1 files changed

// File: rtl/binary_search_guesser.sv
// Binary-search initiator: drives probe values into an external magnitude
// comparator and narrows [lo, hi] from its EQ/LT/GT answer until found or inconsistent.
module binary_search_guesser #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             eq,
   input  logic             lt,
   input  logic             gt,
   output logic [WIDTH-1:0] guess,
   output logic [WIDTH-1:0] found,
   output logic [7:0]       steps,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // state | meaning
   // IDLE  | waiting for start; guess/found/steps/err hold
   // PROBE | issue midpoint of [lo, hi] as the next guess
   // EVAL  | comparator flags settle; narrow range or finish
   // FIN   | one-cycle done pulse, then back to IDLE
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      EVAL  = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam logic [WIDTH:0] MAX_VAL = {1'b0, {WIDTH{1'b1}}};

   state_t           state, state_nxt;
   logic [WIDTH:0]   lo, lo_nxt;
   logic [WIDTH:0]   hi, hi_nxt;
   logic [WIDTH-1:0] guess_nxt;
   logic [WIDTH-1:0] found_nxt;
   logic [7:0]       steps_nxt;
   logic             err_nxt;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   guess_inc;
   logic [WIDTH:0]   guess_dec;
   logic [2:0]       flags;

   // lo + hi never exceeds 2*MAX, so the WIDTH+1 bit sum cannot overflow
   assign sum       = lo + hi;
   assign guess_inc = {1'b0, guess} + {{WIDTH{1'b0}}, 1'b1};
   assign guess_dec = {1'b0, guess} - {{WIDTH{1'b0}}, 1'b1};
   assign flags     = {eq, lt, gt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lo    <= '0;
         hi    <= '0;
         guess <= '0;
         found <= '0;
         steps <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         lo    <= lo_nxt;
         hi    <= hi_nxt;
         guess <= guess_nxt;
         found <= found_nxt;
         steps <= steps_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lo_nxt    = lo;
      hi_nxt    = hi;
      guess_nxt = guess;
      found_nxt = found;
      steps_nxt = steps;
      err_nxt   = err;

      case (state)
         IDLE: begin
            if (start) begin
               lo_nxt    = '0;
               hi_nxt    = MAX_VAL;
               steps_nxt = '0;
               err_nxt   = 1'b0;
               state_nxt = PROBE;
            end
         end

         PROBE: begin
            guess_nxt = WIDTH'(sum >> 1);
            if (steps != 8'hff) begin
               steps_nxt = steps + 8'd1;
            end
            state_nxt = EVAL;
         end

         EVAL: begin
            state_nxt = FIN;
            case (flags)
               3'b100: found_nxt = guess;
               3'b010: begin
                  // a top-of-range LT means the comparator contradicts the range
                  if ((&guess) || (guess_inc > hi)) begin
                     err_nxt = 1'b1;
                  end else begin
                     lo_nxt    = guess_inc;
                     state_nxt = PROBE;
                  end
               end
               3'b001: begin
                  if ((guess == '0) || (guess_dec < lo)) begin
                     err_nxt = 1'b1;
                  end else begin
                     hi_nxt    = guess_dec;
                     state_nxt = PROBE;
                  end
               end
               default: err_nxt = 1'b1;
            endcase
         end

         FIN: state_nxt = IDLE;

         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == PROBE) || (state == EVAL);
   assign done = (state == FIN);

endmodule
